// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative multiply/divide unit
package muldiv_pkg;

  localparam int MULDIV_ITER = 8;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  // The stored remainder is always below the divisor, so it fits in WIDTH bits;
  // the shifted partial needs WIDTH+1 bits before the compare.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Shift in the next dividend bit, subtract the divisor when it fits.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted[WIDTH-1:0] - divisor_i;
    q_o     = (shifted >= {1'b0, divisor_i});
    rem_o   = q_o ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned MUL/MULHU/DIVU/REMU with single write-back pulse
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       rd,
  output logic             busy,
  output logic [WIDTH-1:0] wd,
  output logic [4:0]       wa,
  output logic             we
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  muldiv_state_t      state_q;
  muldiv_op_t         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [4:0]         rd_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic               busy_q;
  logic               we_q;
  logic [WIDTH-1:0]   wd_q;
  logic [4:0]         wa_q;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic               q_bit;
  logic [WIDTH-1:0]   result_d;

  // quo_q doubles as the dividend shifter: its MSB feeds the step while quotient bits enter at the LSB.
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[WIDTH-1]),
    .divisor_i (b_q),
    .rem_o     (rem_d),
    .q_o       (q_bit)
  );

  // Next iteration of both datapaths and the result as it will stand after this edge.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
    quo_d   = {quo_q[WIDTH-2:0], q_bit};
    case (op_q)
      OP_MUL:   result_d = prod_d[WIDTH-1:0];
      OP_MULHU: result_d = prod_d[2*WIDTH-1:WIDTH];
      OP_DIVU:  result_d = quo_d;
      default:  result_d = rem_d;
    endcase
  end

  // Control FSM with registered busy/write-back outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      wa_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          we_q <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= muldiv_op_t'(op);
            rd_q   <= rd;
            cnt_q  <= '0;
            prod_q <= {{WIDTH{1'b0}}, b};
            rem_q  <= '0;
            quo_q  <= a;
            busy_q <= 1'b1;
            if (op[1] && (b == '0)) begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              state_q <= S_DONE;
              we_q    <= (rd != 5'd0);
              wd_q    <= op[0] ? a : '1;
              wa_q    <= rd;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          prod_q <= prod_d;
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            we_q    <= (rd_q != 5'd0);
            wd_q    <= result_d;
            wa_q    <= rd_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          we_q    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign we   = we_q;
  assign wd   = wd_q;
  assign wa   = wa_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [4:0] rd;
  logic       busy;
  logic [7:0] wd;
  logic [4:0] wa;
  logic       we;

  int n_checks;
  int n_fail;

  muldiv_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .rd    (rd),
    .busy  (busy),
    .wd    (wd),
    .wa    (wa),
    .we    (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and watch it until busy drops (bounded).
  task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] aa,
                       input logic [7:0] bb, input logic [4:0] r,
                       input logic [7:0] exp_wd, input int exp_busy, input bit exp_we);
    int busy_n;
    int we_n;
    int we_at;
    @(negedge clk);
    op = o; a = aa; b = bb; rd = r; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_n = 0; we_n = 0; we_at = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (we) begin
        we_n++;
        we_at = i;
      end
      if (!busy) break;
    end
    check({tag, ".busy_cycles"}, busy_n, exp_busy);
    check({tag, ".we_count"}, we_n, exp_we ? 1 : 0);
    if (exp_we) check({tag, ".we_cycle"}, we_at, exp_busy);
    check({tag, ".wd"}, wd, exp_wd);
    check({tag, ".wa"}, wa, r);
  endtask

  initial begin
    int we_n;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.we", we, 0);
    check("reset.wd", wd, 0);
    check("reset.wa", wa, 0);

    do_op("mul_13x11",   2'b00, 8'd13,  8'd11, 5'd5,  8'h8F, 9, 1'b1);
    do_op("mulhu_13x11", 2'b01, 8'd13,  8'd11, 5'd5,  8'h00, 9, 1'b1);
    do_op("mul_200x200", 2'b00, 8'd200, 8'd200, 5'd6, 8'h40, 9, 1'b1);
    do_op("mulhu_200",   2'b01, 8'd200, 8'd200, 5'd6, 8'h9C, 9, 1'b1);
    do_op("divu_200_7",  2'b10, 8'd200, 8'd7,  5'd7,  8'h1C, 9, 1'b1);
    do_op("remu_200_7",  2'b11, 8'd200, 8'd7,  5'd8,  8'h04, 9, 1'b1);
    do_op("divu_ff_1",   2'b10, 8'hFF,  8'd1,  5'd9,  8'hFF, 9, 1'b1);
    do_op("divu_by0",    2'b10, 8'h5A,  8'd0,  5'd10, 8'hFF, 1, 1'b1);
    do_op("remu_by0",    2'b11, 8'h5A,  8'd0,  5'd11, 8'h5A, 1, 1'b1);
    do_op("mul_rd0",     2'b00, 8'd13,  8'd11, 5'd0,  8'h8F, 9, 1'b0);

    // start pulses during RUN and DONE must be ignored
    @(negedge clk);
    op = 2'b00; a = 8'd13; b = 8'd11; rd = 5'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    we_n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (we) begin
        we_n++;
        check("ignore.wd", wd, 8'h8F);
        check("ignore.wa", wa, 5'd5);
      end
      if (i == 10) check("ignore.busy_after_done", busy, 0);
      if (i == 11) check("ignore.busy_not_restarted", busy, 0);
      if (i == 3 || i == 9) begin
        op = 2'b10; a = 8'd9; b = 8'd3; rd = 5'd12; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("ignore.we_count", we_n, 1);

    // reset in the middle of iterating
    @(negedge clk);
    op = 2'b00; a = 8'd200; b = 8'd200; rd = 5'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.busy", busy, 0);
    check("midrst.we", we, 0);
    check("midrst.wd", wd, 0);
    check("midrst.wa", wa, 0);
    we_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (we || busy) we_n++;
    end
    check("midrst.no_activity", we_n, 0);
    do_op("mul_3x3", 2'b00, 8'd3, 8'd3, 5'd2, 8'h09, 9, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide execution unit for the 8-bit processor datapath. It consumes the two register-file read operands (rd1/rd2 values), computes MUL, MULHU, DIVU or REMU over 8 iteration cycles, and issues one write-back pulse (data, address, enable) that drives the register file write port (wd3/wa3/we3). The control unit must hold off further issue while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  issue request; sampled only in IDLE.
- `op`  in  2  operation: 00 MUL (low half), 01 MULHU (high half), 10 DIVU (quotient), 11 REMU (remainder).
- `a`  in  WIDTH  operand A (rs1 value; multiplicand or dividend).
- `b`  in  WIDTH  operand B (rs2 value; multiplier or divisor).
- `rd`  in  5  destination register address.
- `busy`  out  1  high whenever the unit is not in IDLE.
- `wd`  out  WIDTH  write-back data, valid while `we` is high.
- `wa`  out  5  write-back address, valid while `we` is high.
- `we`  out  1  write-back enable, one-cycle pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 at an edge captures `a`, `b`, `op`, `rd`, clears the iteration counter, and goes to RUN. Division with `b`=0 goes straight to DONE instead.
- RUN: one iteration per edge. The counter counts 0..WIDTH-1. The edge on which the counter equals WIDTH-1 performs the last iteration and goes to DONE.
- DONE: `we`=1 for exactly this cycle, then IDLE on the next edge.
- `start` in RUN or DONE is ignored. There is no queueing, and captured operands do not change.
- Multiply: shift-add on a 2·WIDTH product register. When the multiplier LSB is 1, add the multiplicand into the upper half. Then shift right one bit, with the carry entering the MSB. MUL returns product[WIDTH-1:0]; MULHU returns product[2·WIDTH-1:WIDTH].
- Divide: restoring division. Use a (WIDTH+1)-bit partial remainder and shift in the dividend MSB-first. If partial ≥ divisor, subtract it and shift in quotient bit 1; otherwise shift in 0.
- Divide by zero (RISC-V semantics): DIVU returns all ones (0xFF); REMU returns `a`. No exception is raised.
- `rd`=0: the operation runs with normal latency, but `we` is forced to 0 in DONE. `wd` and `wa` still show the result.
- `wd`/`wa` hold their last value outside DONE. Consumers qualify them with `we` only.

## Timing
- Reset values: state IDLE; `busy`=0, `we`=0, `wd`=0, `wa`=0. Counter and internal registers are cleared.
- Reset is synchronous and overrides everything, including mid-RUN or DONE. The next cycle is IDLE with no write pulse, and the captured operation is discarded.
- Normal latency (start accepted at edge N):
  - RUN for cycles N..N+7, `busy`=1.
  - DONE in the cycle after edge N+8, with `we`=1.
  - IDLE after edge N+9.
  - `busy` is high for 9 cycles.
- Divide-by-zero latency: DONE in the cycle after edge N, then IDLE after N+1.
- Earliest re-issue: `start` sampled at the edge that leaves DONE is ignored. The first accepted `start` is at the edge after returning to IDLE.
- `busy` and `we` are decoded from state only, with no combinational path from `start`.
- A write lands in the register file at the edge that ends DONE. The control unit must stall reads of `rd` until `busy`=0.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_t` enum (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU).
  - `muldiv_state_t` enum (S_IDLE, S_RUN, S_DONE).
  - Constant `MULDIV_ITER = 8`.
- Sub-module `div_step`: combinational single restoring-division step. Inputs are the partial remainder, dividend bit and divisor; outputs are the new partial remainder and the quotient bit. Multiply stays inline.

## Test plan
- MUL `a`=13, `b`=11, `rd`=5 → `we` pulse exactly 9 cycles after the start edge, `wd`=0x8F, `wa`=5. MULHU with the same operands → 0x00.
- MUL/MULHU `a`=200, `b`=200 → 0x40 / 0x9C; `busy` is high for exactly 9 cycles.
- DIVU `a`=200, `b`=7 → 28 (0x1C); REMU → 4. Also DIVU `a`=0xFF, `b`=1 → 0xFF.
- DIVU and REMU with `a`=0x5A, `b`=0 → 0xFF and 0x5A respectively, with `we` in the cycle after the start edge and `busy` high for 1 cycle.
- `start` pulsed again during RUN and during DONE with different operands → ignored, and the original result is written once. MUL with `rd`=0 → `we` never asserts.
- `rst` asserted during iteration 4 → next cycle IDLE, all outputs 0, no `we` pulse. A fresh MUL 3×3 then produces 0x09.
